// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480@60Hz timing constants, pixel colour type and PMOD packing
//
// Purpose: shared timing constants for the horizontal/vertical counters, a
// 2-bit-per-channel colour struct, and a helper that packs colour plus syncs
// into the TinyTapeout VGA PMOD bit order.
package vga_pkg;

  localparam logic [9:0] H_VIS  = 10'd640;
  localparam logic [9:0] H_FP   = 10'd16;
  localparam logic [9:0] H_SYNC = 10'd96;
  localparam logic [9:0] H_TOT  = 10'd800;

  localparam logic [9:0] V_VIS  = 10'd480;
  localparam logic [9:0] V_FP   = 10'd10;
  localparam logic [9:0] V_SYNC = 10'd2;
  localparam logic [9:0] V_TOT  = 10'd525;

  // Sync pulse windows, start inclusive / end exclusive.
  localparam logic [9:0] H_SYNC_START = H_VIS + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_VIS + H_FP + H_SYNC;
  localparam logic [9:0] V_SYNC_START = V_VIS + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_VIS + V_FP + V_SYNC;

  // Upper half of the screen shows the bar, lower half the bit stripes.
  localparam logic [9:0] V_HALF      = 10'd240;
  localparam logic [9:0] STRIPE_W    = 10'd40;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  // PMOD order: [7]hsync [6]B0 [5]G0 [4]R0 [3]vsync [2]B1 [1]G1 [0]R1
  function automatic logic [7:0] pack_pmod(input rgb_t c, input logic hs, input logic vs);
    return {hs, c.b[0], c.g[0], c.r[0], vs, c.b[1], c.g[1], c.r[1]};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480@60Hz horizontal/vertical counters and sync decode
//
// Ports:
//   clk, rst_n  pixel clock, async active-low reset
//   h, v        current pixel column (0..799) and line (0..524)
//   hsync       active-low, low for h 656..751
//   vsync       active-low, low for v 490..491
//   visible     h<640 && v<480
// Outputs are combinational decodes of the counter flops; the top registers them.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hsync,
  output logic       vsync,
  output logic       visible
);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == H_TOT - 10'd1) begin
      h_d = 10'd0;
      v_d = (v_q == V_TOT - 10'd1) ? 10'd0 : v_q + 10'd1;
    end else begin
      h_d = h_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= 10'd0;
      v_q <= 10'd0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h       = h_q;
  assign v       = v_q;
  assign hsync   = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
  assign vsync   = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
  assign visible = (h_q < H_VIS) && (v_q < V_VIS);

endmodule

// File: rtl/algofoogle_vgaringosc.sv
// rtl/algofoogle_vgaringosc.sv - VGA timing plus ring-oscillator frequency meter (TT top)
//
// Ports:
//   clk      pixel clock (25.175 MHz nominal)
//   rst_n    async active-low reset, also clears the oscillator-domain counter
//   ena      TT enable, ignored
//   ui_in    [0] ring enable, [3:1] bar shift, [4] uio byte select,
//            [6] external osc, [7] osc source (0 ring, 1 ui_in[6])
//   uo_out   VGA PMOD (registered, 1 clk after h/v)
//   uio_in   unused
//   uio_out  selected byte of the per-frame measurement
//   uio_oe   all outputs enabled
module algofoogle_vgaringosc
  import vga_pkg::*;
#(
  parameter int RING_STAGES = 31,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [9:0] h, v;
  logic       hsync, vsync, visible;

  vga_timing u_timing (
    .clk     (clk),
    .rst_n   (rst_n),
    .h       (h),
    .v       (v),
    .hsync   (hsync),
    .vsync   (vsync),
    .visible (visible)
  );

  // ------------------------------------------------------------------
  // Ring oscillator: a NAND (enable gate) followed by RING_STAGES-1
  // inverters, giving RING_STAGES inversions around the loop. With the
  // enable low the NAND output is pinned high and the ring is static.
  // ------------------------------------------------------------------
  logic ring_out;

`ifdef SYNTHESIS
  (* keep = "true", dont_touch = "true" *) logic [RING_STAGES-1:0] ring_n;

  assign ring_n[0] = ~(ui_in[0] & ring_n[RING_STAGES-1]);
  for (genvar i = 1; i < RING_STAGES; i++) begin : g_inv
    assign ring_n[i] = ~ring_n[i-1];
  end
  assign ring_out = ring_n[RING_STAGES-1];
`else
  // Behavioural stand-in: the loop delay is modelled as RING_STAGES clk
  // periods per half cycle, so simulation sees a slow, clean square wave.
  localparam int DLY_W = $clog2(RING_STAGES + 1);

  logic [DLY_W-1:0] dly_q, dly_d;
  logic             ring_q, ring_d;

  always_comb begin
    dly_d  = dly_q;
    ring_d = ring_q;
    if (ui_in[0]) begin
      if (dly_q == DLY_W'(RING_STAGES - 1)) begin
        dly_d  = '0;
        ring_d = ~ring_q;
      end else begin
        dly_d = dly_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q  <= '0;
      ring_q <= 1'b0;
    end else begin
      dly_q  <= dly_d;
      ring_q <= ring_d;
    end
  end

  assign ring_out = ring_q;
`endif

  // ------------------------------------------------------------------
  // Oscillator domain: binary edge counter plus a registered gray copy,
  // so the value crossing into clk changes only one bit per edge.
  // ------------------------------------------------------------------
  logic             osc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] gray_q, gray_d;

  assign osc    = ui_in[7] ? ui_in[6] : ring_out;
  assign cnt_d  = cnt_q + 1'b1;
  assign gray_d = cnt_d ^ (cnt_d >> 1);

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      gray_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
    end
  end

  // ------------------------------------------------------------------
  // clk domain: 2-FF synchronizer, gray-to-binary, per-frame delta.
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0] sync_bin;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] measure_q, measure_d;
  logic             frame_start;

  always_comb begin
    sync_bin = '0;
    for (int i = 0; i < CNT_W; i++) begin
      sync_bin[i] = ^(sync2_q >> i);
    end
  end

  assign frame_start = (h == 10'd0) && (v == 10'd0);

  // Modular subtraction absorbs free-running counter wrap.
  always_comb begin
    measure_d = measure_q;
    prev_d    = prev_q;
    if (frame_start) begin
      measure_d = sync_bin - prev_q;
      prev_d    = sync_bin;
    end
  end

  // ------------------------------------------------------------------
  // Pixel generation
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] bar_len;
  logic             bar_on;
  logic [3:0]       stripe_idx;
  logic             stripe_bit;
  rgb_t             rgb;
  logic [7:0]       uo_q, uo_d;

  // h is always below 640 when visible, so the 640 clamp falls out for free.
  assign bar_len    = measure_q >> ui_in[3:1];
  assign bar_on     = {{(CNT_W-10){1'b0}}, h} < bar_len;
  assign stripe_idx = 4'(h / STRIPE_W);
  assign stripe_bit = measure_q[4'd15 - stripe_idx];

  always_comb begin
    rgb = '0;
    if (visible) begin
      if (v < V_HALF) begin
        if (bar_on) rgb = '{r: 2'b11, g: 2'b11, b: 2'b11};
      end else if (stripe_bit) begin
        rgb.g = 2'b11;
      end else begin
        rgb.b = 2'b01;
      end
    end
    uo_d = pack_pmod(rgb, hsync, vsync);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      measure_q <= '0;
      uo_q      <= 8'h88;
    end else begin
      sync1_q   <= gray_q;
      sync2_q   <= sync1_q;
      prev_q    <= prev_d;
      measure_q <= measure_d;
      uo_q      <= uo_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = ui_in[4] ? measure_q[15:8] : measure_q[7:0];
  assign uio_oe  = 8'hFF;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[5]};

endmodule

// File: tb/tb_algofoogle_vgaringosc.sv
// tb/tb_algofoogle_vgaringosc.sv - directed self-checking bench for algofoogle_vgaringosc
module tb_algofoogle_vgaringosc;

  localparam int FRAME = 420000;
  localparam int LINE  = 800;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_ctrl;
  logic       ext_osc = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  algofoogle_vgaringosc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   ({ui_ctrl[7], ext_osc, ui_ctrl[5:0]}),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // External oscillator: period 1000 time units = 100 clks, offset from clk edges.
  initial begin
    #3;
    forever #500 ext_osc = ~ext_osc;
  end

  // Clock edges since reset release; after edge k, uo_out shows pixel k-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Advance to the negedge where uo_out shows absolute pixel p.
  task automatic goto(input int p);
    int guard;
    guard = 0;
    while (cyc < p + 1 && guard < 1200000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != p + 1) begin
      checks++;
      failures++;
      $display("FAIL goto pixel=%0d cyc=%0d", p, cyc);
    end
  endtask

  task automatic test_reset;
    ena     = 1'b1;
    uio_in  = 8'h00;
    ui_ctrl = 8'h86;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (uo_out !== 8'h88) begin failures++; $display("FAIL reset_uo_out got=%h exp=88", uo_out); end
    checks++;
    if (uio_oe !== 8'hFF) begin failures++; $display("FAIL reset_uio_oe got=%h exp=ff", uio_oe); end
    checks++;
    if (uio_out !== 8'h00) begin failures++; $display("FAIL reset_uio_out got=%h exp=00", uio_out); end
    rst_n = 1'b1;
    goto(0);
    checks++;
    if (uo_out !== 8'h88) begin failures++; $display("FAIL first_pixel got=%h exp=88", uo_out); end
  endtask

  task automatic test_hsync;
    int lows;
    goto(655);
    checks++;
    if (uo_out[7] !== 1'b1) begin failures++; $display("FAIL hsync_h655 got=%b exp=1", uo_out[7]); end
    lows = 0;
    for (int p = 656; p < 800; p++) begin
      goto(p);
      if (uo_out[7] === 1'b0) lows++;
    end
    checks++;
    if (lows != 96) begin failures++; $display("FAIL hsync_width got=%0d exp=96", lows); end
    goto(LINE + 655);
    checks++;
    if (uo_out[7] !== 1'b1) begin failures++; $display("FAIL hsync_l1_h655 got=%b exp=1", uo_out[7]); end
    goto(LINE + 656);
    checks++;
    if (uo_out[7] !== 1'b0) begin failures++; $display("FAIL hsync_period got=%b exp=0", uo_out[7]); end
  endtask

  task automatic test_vsync;
    goto(490 * LINE - 1);
    checks++;
    if (uo_out[3] !== 1'b1) begin failures++; $display("FAIL vsync_before got=%b exp=1", uo_out[3]); end
    goto(490 * LINE);
    checks++;
    if (uo_out[3] !== 1'b0) begin failures++; $display("FAIL vsync_start got=%b exp=0", uo_out[3]); end
    goto(492 * LINE - 1);
    checks++;
    if (uo_out[3] !== 1'b0) begin failures++; $display("FAIL vsync_last got=%b exp=0", uo_out[3]); end
    goto(492 * LINE);
    checks++;
    if (uo_out[3] !== 1'b1) begin failures++; $display("FAIL vsync_end got=%b exp=1", uo_out[3]); end
    goto(FRAME + 490 * LINE - 1);
    checks++;
    if (uo_out[3] !== 1'b1) begin failures++; $display("FAIL vsync_f1_before got=%b exp=1", uo_out[3]); end
    goto(FRAME + 490 * LINE);
    checks++;
    if (uo_out[3] !== 1'b0) begin failures++; $display("FAIL vsync_period got=%b exp=0", uo_out[3]); end
  endtask

  // measure = 4200 = 16'h1068
  task automatic test_measure;
    goto(2 * FRAME);
    checks++;
    if (uio_out < 8'h67 || uio_out > 8'h69) begin
      failures++;
      $display("FAIL measure_lo got=%h exp=68", uio_out);
    end
    ui_ctrl[4] = 1'b1;
    #1;
    checks++;
    if (uio_out !== 8'h10) begin failures++; $display("FAIL measure_hi got=%h exp=10", uio_out); end
    ui_ctrl[4] = 1'b0;
    #1;
  endtask

  // 4200 >> 3 = 525: white for h 0..524 on line 10
  task automatic test_bar;
    int base;
    base = 2 * FRAME + 10 * LINE;
    goto(base + 0);
    checks++;
    if (uo_out !== 8'hFF) begin failures++; $display("FAIL bar_h0 got=%h exp=ff", uo_out); end
    goto(base + 524);
    checks++;
    if (uo_out !== 8'hFF) begin failures++; $display("FAIL bar_h524 got=%h exp=ff", uo_out); end
    goto(base + 525);
    checks++;
    if (uo_out !== 8'h88) begin failures++; $display("FAIL bar_h525 got=%h exp=88", uo_out); end
    goto(base + 639);
    checks++;
    if (uo_out !== 8'h88) begin failures++; $display("FAIL bar_h639 got=%h exp=88", uo_out); end
    goto(base + 640);
    checks++;
    if (uo_out !== 8'h88) begin failures++; $display("FAIL bar_h640 got=%h exp=88", uo_out); end
  endtask

  // Green stripe = 8'hAA, blue-only stripe = 8'hC8
  task automatic test_stripes;
    int base;
    base = 2 * FRAME + 300 * LINE;
    goto(base + 0);
    checks++;
    if (uo_out !== 8'hC8) begin failures++; $display("FAIL stripe_h0 got=%h exp=c8", uo_out); end
    goto(base + 39);
    checks++;
    if (uo_out !== 8'hC8) begin failures++; $display("FAIL stripe_h39 got=%h exp=c8", uo_out); end
    goto(base + 120);
    checks++;
    if (uo_out !== 8'hAA) begin failures++; $display("FAIL stripe_h120 got=%h exp=aa", uo_out); end
    goto(base + 159);
    checks++;
    if (uo_out !== 8'hAA) begin failures++; $display("FAIL stripe_h159 got=%h exp=aa", uo_out); end
    goto(base + 160);
    checks++;
    if (uo_out !== 8'hC8) begin failures++; $display("FAIL stripe_h160 got=%h exp=c8", uo_out); end
    goto(base + 360);
    checks++;
    if (uo_out !== 8'hAA) begin failures++; $display("FAIL stripe_h360 got=%h exp=aa", uo_out); end
  endtask

  task automatic test_reset_mid;
    rst_n = 1'b0;
    #1;
    checks++;
    if (uo_out !== 8'h88) begin failures++; $display("FAIL midrst_uo got=%h exp=88", uo_out); end
    checks++;
    if (uio_out !== 8'h00) begin failures++; $display("FAIL midrst_measure got=%h exp=00", uio_out); end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    goto(0);
    checks++;
    if (uo_out !== 8'h88) begin failures++; $display("FAIL midrst_pix0 got=%h exp=88", uo_out); end
    checks++;
    if (uio_out !== 8'h00) begin failures++; $display("FAIL midrst_measure_after got=%h exp=00", uio_out); end
    goto(655);
    checks++;
    if (uo_out[7] !== 1'b1) begin failures++; $display("FAIL midrst_h655 got=%b exp=1", uo_out[7]); end
    goto(656);
    checks++;
    if (uo_out[7] !== 1'b0) begin failures++; $display("FAIL midrst_h656 got=%b exp=0", uo_out[7]); end
  endtask

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b0;
    uio_in  = 8'h00;
    ui_ctrl = 8'h00;
    test_reset();
    test_hsync();
    test_vsync();
    test_measure();
    test_bar();
    test_stripes();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
